// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS core.
// Steps each instruction through fetch, decode, execute, memory and
// writeback, and drives every datapath enable and mux select. ALUOp goes
// to the ALU decoder, which combines it with Opcode/Funct.
module mips_multicycle_ctrl #(
  parameter bit JUMP_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ZeroExt,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ITYPEEX = 4'd9,
    ITYPEWB = 4'd10,
    JEX     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_e state_q, state_d;

  // Raw (pre-reset-gating) versions of the enables that must stay low in reset
  logic memWriteRaw, irWriteRaw, regWriteRaw, illegalRaw;
  logic pcWrite, branch;

  // State register; reset puts the machine back at FETCH immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DECODE also flags unsupported opcodes
  always_comb begin
    state_d    = FETCH;
    illegalRaw = 1'b0;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        case (Opcode)
          OP_LW, OP_SW:                      state_d = MEMADR;
          OP_RTYPE:                          state_d = RTYPEEX;
          OP_BEQ:                            state_d = BEQEX;
          OP_ADDI, OP_ORI, OP_XORI, OP_SLTI: state_d = ITYPEEX;
          OP_J: begin
            if (JUMP_EN) begin
              state_d = JEX;
            end else begin
              illegalRaw = 1'b1;
            end
          end
          default: illegalRaw = 1'b1;
        endcase
      end
      MEMADR:  state_d = (Opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ITYPEEX: state_d = ITYPEWB;
      default: state_d = FETCH;
    endcase
  end

  // Per-state datapath controls; unused encodings fall back to FETCH muxes
  always_comb begin
    IorD        = 1'b0;
    memWriteRaw = 1'b0;
    irWriteRaw  = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    regWriteRaw = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ZeroExt     = 1'b0;
    ALUOp       = 2'b00;
    PCSrc       = 2'b00;
    pcWrite     = 1'b0;
    branch      = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcB    = 2'b01;
        irWriteRaw = 1'b1;
        pcWrite    = 1'b1;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        IorD = 1'b1;
      end
      MEMWB: begin
        MemtoReg    = 1'b1;
        regWriteRaw = 1'b1;
      end
      MEMWR: begin
        IorD        = 1'b1;
        memWriteRaw = 1'b1;
      end
      RTYPEEX: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      RTYPEWB: begin
        RegDst      = 1'b1;
        regWriteRaw = 1'b1;
      end
      BEQEX: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        branch  = 1'b1;
      end
      ITYPEEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
        ZeroExt = (Opcode == OP_ORI) || (Opcode == OP_XORI);
      end
      ITYPEWB: begin
        regWriteRaw = 1'b1;
      end
      JEX: begin
        PCSrc   = 2'b10;
        pcWrite = 1'b1;
      end
      default: begin
        ALUSrcB = 2'b01;
      end
    endcase
  end

  // Enables are held low while reset is asserted so no write sneaks through
  assign MemWrite  = memWriteRaw & reset_n;
  assign IRWrite   = irWriteRaw & reset_n;
  assign RegWrite  = regWriteRaw & reset_n;
  assign IllegalOp = illegalRaw & reset_n;
  assign PCEn      = (pcWrite | (branch & Zero)) & reset_n;
  assign State     = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized self-checking bench for mips_multicycle_ctrl. Two instances
// (jump supported / not supported) run independent random instruction
// streams against a path-and-table reference model.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       iord;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memtoReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       zeroExt;
    logic [1:0] aluOp;
    logic [1:0] pcSrc;
    logic       pcEn;
    logic       illegalOp;
  } ctrl_t;

  logic       clk;
  logic       reset_n;
  logic       zero;
  logic [5:0] opcA, opcB;

  logic iordA, memWriteA, irWriteA, regDstA, memtoRegA, regWriteA, aluSrcAA, zeroExtA, pcEnA, illegalA;
  logic [1:0] aluSrcBA, aluOpA, pcSrcA;
  logic [3:0] stateA;
  logic iordB, memWriteB, irWriteB, regDstB, memtoRegB, regWriteB, aluSrcAB, zeroExtB, pcEnB, illegalB;
  logic [1:0] aluSrcBB, aluOpB, pcSrcB;
  logic [3:0] stateB;

  ctrl_t actA, actB;
  assign actA = {iordA, memWriteA, irWriteA, regDstA, memtoRegA, regWriteA, aluSrcAA,
                 aluSrcBA, zeroExtA, aluOpA, pcSrcA, pcEnA, illegalA};
  assign actB = {iordB, memWriteB, irWriteB, regDstB, memtoRegB, regWriteB, aluSrcAB,
                 aluSrcBB, zeroExtB, aluOpB, pcSrcB, pcEnB, illegalB};

  int vectors = 0;
  int miscompares = 0;

  mips_multicycle_ctrl #(.JUMP_EN(1'b1)) dutA (
    .clk(clk), .reset_n(reset_n), .Opcode(opcA), .Zero(zero),
    .IorD(iordA), .MemWrite(memWriteA), .IRWrite(irWriteA), .RegDst(regDstA),
    .MemtoReg(memtoRegA), .RegWrite(regWriteA), .ALUSrcA(aluSrcAA), .ALUSrcB(aluSrcBA),
    .ZeroExt(zeroExtA), .ALUOp(aluOpA), .PCSrc(pcSrcA), .PCEn(pcEnA),
    .IllegalOp(illegalA), .State(stateA)
  );

  mips_multicycle_ctrl #(.JUMP_EN(1'b0)) dutB (
    .clk(clk), .reset_n(reset_n), .Opcode(opcB), .Zero(zero),
    .IorD(iordB), .MemWrite(memWriteB), .IRWrite(irWriteB), .RegDst(regDstB),
    .MemtoReg(memtoRegB), .RegWrite(regWriteB), .ALUSrcA(aluSrcAB), .ALUSrcB(aluSrcBB),
    .ZeroExt(zeroExtB), .ALUOp(aluOpB), .PCSrc(pcSrcB), .PCEn(pcEnB),
    .IllegalOp(illegalB), .State(stateB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: expected controls per state, plus state path per opcode
  ctrl_t      ctrlTable [12];
  logic [5:0] legalOps  [10];
  int         path      [2][6];
  int         pathLen   [2];
  int         pathIdx   [2];
  logic [5:0] curOpc    [2];

  function automatic ctrl_t mkRow(logic iord, logic mw, logic ir, logic rd, logic m2r,
                                  logic rw, logic asa, logic [1:0] asb, logic [1:0] aop,
                                  logic [1:0] pcs, logic pce);
    ctrl_t c;
    c = '0;
    c.iord = iord; c.memWrite = mw; c.irWrite = ir; c.regDst = rd; c.memtoReg = m2r;
    c.regWrite = rw; c.aluSrcA = asa; c.aluSrcB = asb; c.aluOp = aop; c.pcSrc = pcs;
    c.pcEn = pce;
    return c;
  endfunction

  function automatic bit isLegal(logic [5:0] opc, bit jumpEn);
    for (int i = 0; i < 9; i++) if (legalOps[i] == opc) return 1'b1;
    return jumpEn && (opc == legalOps[9]);
  endfunction

  function automatic ctrl_t expectedCtrl(int st, logic [5:0] opc, logic z, bit jumpEn);
    ctrl_t c;
    c = ctrlTable[st];
    if (st == 1) c.illegalOp = !isLegal(opc, jumpEn);
    if (st == 9) c.zeroExt = (opc == 6'b001101) || (opc == 6'b001110);
    if (st == 8) c.pcEn = z;
    return c;
  endfunction

  // Instruction class decides the sequence of states visited from FETCH
  task automatic buildPath(input int d, input logic [5:0] opc, input bit jumpEn);
    path[d][0] = 0;
    path[d][1] = 1;
    pathIdx[d] = 0;
    curOpc[d]  = opc;
    if (opc == 6'b100011) begin
      path[d][2] = 2; path[d][3] = 3; path[d][4] = 4; pathLen[d] = 5;
    end else if (opc == 6'b101011) begin
      path[d][2] = 2; path[d][3] = 5; pathLen[d] = 4;
    end else if (opc == 6'b000000) begin
      path[d][2] = 6; path[d][3] = 7; pathLen[d] = 4;
    end else if (opc == 6'b000100) begin
      path[d][2] = 8; pathLen[d] = 3;
    end else if (opc == 6'b001000 || opc == 6'b001101 || opc == 6'b001110 || opc == 6'b001010) begin
      path[d][2] = 9; path[d][3] = 10; pathLen[d] = 4;
    end else if (opc == 6'b000010 && jumpEn) begin
      path[d][2] = 11; pathLen[d] = 3;
    end else begin
      pathLen[d] = 2;
    end
  endtask

  function automatic logic [5:0] pickOpcode();
    if ($urandom_range(0, 1) == 0) return legalOps[$urandom_range(0, 9)];
    return 6'($urandom);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int d);
    if (d == 0) opcA = curOpc[0];
    else        opcB = curOpc[1];
  endtask

  task automatic checkDut(input int d, input int cyc);
    int    st;
    ctrl_t exp;
    st  = path[d][pathIdx[d]];
    exp = expectedCtrl(st, curOpc[d], zero, d == 0);
    if (d == 0) begin
      checkOutput($sformatf("A.state c%0d op%b", cyc, curOpc[0]), 32'(stateA), 32'(st));
      checkOutput($sformatf("A.ctrl c%0d st%0d op%b", cyc, st, curOpc[0]), 32'(actA), 32'(exp));
    end else begin
      checkOutput($sformatf("B.state c%0d op%b", cyc, curOpc[1]), 32'(stateB), 32'(st));
      checkOutput($sformatf("B.ctrl c%0d st%0d op%b", cyc, st, curOpc[1]), 32'(actB), 32'(exp));
    end
  endtask

  initial begin
    ctrlTable[0]  = mkRow(0,0,1,0,0,0,0,2'b01,2'b00,2'b00,1);
    ctrlTable[1]  = mkRow(0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
    ctrlTable[2]  = mkRow(0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
    ctrlTable[3]  = mkRow(1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    ctrlTable[4]  = mkRow(0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0);
    ctrlTable[5]  = mkRow(1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    ctrlTable[6]  = mkRow(0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0);
    ctrlTable[7]  = mkRow(0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0);
    ctrlTable[8]  = mkRow(0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
    ctrlTable[9]  = mkRow(0,0,0,0,0,0,1,2'b10,2'b11,2'b00,0);
    ctrlTable[10] = mkRow(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0);
    ctrlTable[11] = mkRow(0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1);
    legalOps = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                 6'b001101, 6'b001110, 6'b001010, 6'b111111, 6'b000010};
    legalOps[8] = 6'b001000;

    reset_n = 1'b0;
    zero    = 1'b0;
    opcA    = 6'b000000;
    opcB    = 6'b000000;

    // Outputs while held in reset
    #3;
    checkOutput("rst.state", 32'(stateA), 32'd0);
    checkOutput("rst.irWrite", 32'(irWriteA), 32'd0);
    checkOutput("rst.pcEn", 32'(pcEnA), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("rel.state", 32'(stateA), 32'd0);
    checkOutput("rel.ctrl", 32'(actA), 32'(ctrlTable[0]));

    // R-type run, then asynchronous reset in the middle of RTYPEWB
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rtwb.state", 32'(stateA), 32'd7);
    checkOutput("rtwb.regWrite", 32'(regWriteA), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midrst.state", 32'(stateA), 32'd0);
    checkOutput("midrst.regWrite", 32'(regWriteA), 32'd0);
    checkOutput("midrst.pcEn", 32'(pcEnA), 32'd0);
    checkOutput("midrst.irWrite", 32'(irWriteA), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("resume.state", 32'(stateA), 32'd0);
    checkOutput("resume.irWrite", 32'(irWriteA), 32'd1);
    checkOutput("resume.pcEn", 32'(pcEnA), 32'd1);

    // Random instruction streams, both DUTs now sitting in FETCH
    for (int d = 0; d < 2; d++) begin
      buildPath(d, pickOpcode(), d == 0);
      applyStimulus(d);
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      zero = 1'($urandom_range(0, 1));
      #1;
      checkDut(0, cyc);
      checkDut(1, cyc);
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        pathIdx[d]++;
        if (pathIdx[d] == pathLen[d]) begin
          buildPath(d, pickOpcode(), d == 0);
          applyStimulus(d);
        end
      end
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
